cpu_2a03_bus_ctrl: RTL and testbench
====================================

Name: cpu_2a03_bus_ctrl

Overview:
Bus-side controller between the T65 core and the NES system bus. It generates the CPU clock-enable, executes OAM DMA when the CPU writes the DMA register, and stalls the CPU via RDY. It also conditions the PPU NMI into a timed pulse for the core. Address, data, divider and DMA geometry are parametrised, making this the generalised successor of the fixed 2A03 wrapper.

Parameters:
- ADDR_W, 16: CPU/bus address width.
- DATA_W, 8: data width.
- CLK_DIV, 12: CLK cycles per CPU tick; legal range ≥1.
- DMA_REG_ADDR, 16'h4014: a CPU write here starts DMA.
- DMA_DST_ADDR, 16'h2004: DMA write target.
- DMA_LEN, 256: bytes per DMA; legal range 1..2^(ADDR_W-DATA_W).
- NMI_HOLD, 2: ticks that CPU_NMI_n is held low per NMI.

Ports:
- CLK  in  1  system clock.
- RESET_n  in  1  synchronous, active-low reset.
- CPU_ADDR  in  ADDR_W  core address.
- CPU_DOUT  in  DATA_W  core write data.
- CPU_RW_n  in  1  core read/write; 0 = write.
- CPU_DIN  out  DATA_W  data returned to the core.
- CPU_ENABLE  out  1  one-CLK tick strobe to the core's Enable input.
- CPU_RDY  out  1  core Rdy input; 0 = stall.
- CPU_NMI_n  out  1  core NMI input.
- NMI_IN_n  in  1  NMI request from the PPU; active low, level.
- BUS_ADDR  out  ADDR_W  system bus address.
- BUS_DOUT  out  DATA_W  system bus write data.
- BUS_RW_n  out  1  system bus read/write.
- BUS_DIN  in  DATA_W  system bus read data.
- DMA_BUSY  out  1  high while DMA owns the bus.

Behaviour:
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - CPU_ENABLE is 1 for exactly one CLK when div_cnt==CLK_DIV-1. With CLK_DIV=1 it is constant 1 out of reset.
  - A "tick" is any CLK with CPU_ENABLE=1. All state below advances only on ticks.
- Parity: flips every tick. Reset value 0 (even).
- Reset values: div_cnt=0, parity=0, state=IDLE, CPU_ENABLE=0, CPU_RDY=1, CPU_NMI_n=1, DMA_BUSY=0, NMI pending=0.
- IDLE muxing (combinational):
  - BUS_ADDR=CPU_ADDR, BUS_DOUT=CPU_DOUT, BUS_RW_n=CPU_RW_n.
  - CPU_DIN=CPU_DOUT when CPU_RW_n=0, otherwise BUS_DIN.
- DMA trigger: on a tick in IDLE with CPU_RW_n=0 and CPU_ADDR==DMA_REG_ADDR:
  - page <= CPU_DOUT[DATA_W-1:0]; idx <= 0.
  - Next state is HALT. The triggering write itself still reaches the bus.
- DMA states:
  - HALT (1 tick): CPU_RDY=0, DMA_BUSY=1, bus mux still passes the CPU.
    - Go to READ if the next tick's parity is even; otherwise go to ALIGN.
  - ALIGN (1 tick): same outputs as HALT; next state READ.
  - READ: BUS_ADDR={page,idx} (zero-extended to ADDR_W), BUS_RW_n=1. On the tick, buf <= BUS_DIN. Next state WRITE.
  - WRITE: BUS_ADDR=DMA_DST_ADDR, BUS_DOUT=buf, BUS_RW_n=0. On the tick, idx++.
    - If idx was DMA_LEN-1: next state IDLE, CPU_RDY=1 and DMA_BUSY=0 from the next CLK. Otherwise next state READ.
  - CPU_RDY=0 and DMA_BUSY=1 in HALT, ALIGN, READ and WRITE.
- Stall length: halted ticks = 1 + align + 2*DMA_LEN, i.e. 513 or 514 for DMA_LEN=256.
- Triggers while not IDLE are ignored (the core is stalled anyway).
- NMI:
  - NMI_IN_n is registered every CLK. A 1→0 transition sets pending.
  - On the next tick with pending=1: CPU_NMI_n <= 0, hold_cnt <= NMI_HOLD, pending <= 0.
  - Each subsequent tick decrements hold_cnt. CPU_NMI_n returns to 1 when hold_cnt reaches 0.
  - An edge arriving during a pulse re-sets pending, so a second pulse follows the first.
  - NMI is independent of DMA and may assert during a stall.
- Reset mid-DMA: synchronous abort to IDLE. CPU_RDY=1 on the CLK after reset is sampled low; buf and idx are discarded.

Optional Feature:
- Macro: CPU_2A03_STALL_CNT_EN.
- Defined: adds output STALL_CNT [15:0].
  - Increments on every tick with CPU_RDY=0 and saturates at 16'hFFFF.
  - Cleared by reset only.
- Not defined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Divider: CLK_DIV=12, run 120 CLKs after reset → exactly 10 CPU_ENABLE pulses, spaced 12 CLKs, first at CLK 12.
- Even-aligned DMA:
  - Stimulus: preload RAM $0200..$02FF with i^8'h5A; CPU writes 8'h02 to $4014 so that HALT lands on an odd-parity tick.
  - Response: exactly 513 halted ticks; 256 writes to $2004 with data 5A,5B,…; read addresses $0200..$02FF in order.
- Odd-aligned DMA: same stimulus shifted by one tick → 514 halted ticks, ALIGN visited once, same data sequence.
- Passthrough: CPU write 8'hA5 to $0000 in IDLE → BUS_RW_n=0, BUS_DOUT=A5, CPU_DIN=A5. CPU read with BUS_DIN=3C → CPU_DIN=3C.
- NMI:
  - NMI_IN_n falls once → CPU_NMI_n low for exactly 2 ticks.
  - Two falls 1 tick apart → two back-to-back pulses.
  - Fall during DMA → pulse occurs while CPU_RDY=0.
- Reset at byte 100 of DMA:
  - RESET_n low for one CLK → next CLK shows IDLE, CPU_RDY=1, DMA_BUSY=0.
  - STALL_CNT=0 when the macro is enabled.
  - A new $4014 write restarts DMA at idx 0.

Source files
------------

// File: rtl/cpu_2a03_bus_ctrl.sv
// Bus-side controller for the T65 core: CPU clock-enable divider, OAM DMA engine with RDY stall, NMI pulse shaping.
// Optional STALL_CNT output is built when CPU_2A03_STALL_CNT_EN is defined.
module cpu_2a03_bus_ctrl #(
  parameter int unsigned          ADDR_W       = 16,
  parameter int unsigned          DATA_W       = 8,
  parameter int unsigned          CLK_DIV      = 12,
  parameter logic [ADDR_W-1:0]    DMA_REG_ADDR = 16'h4014,
  parameter logic [ADDR_W-1:0]    DMA_DST_ADDR = 16'h2004,
  parameter int unsigned          DMA_LEN      = 256,
  parameter int unsigned          NMI_HOLD     = 2
) (
  input  logic              CLK,
  input  logic              RESET_n,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_DOUT,
  input  logic              CPU_RW_n,
  output logic [DATA_W-1:0] CPU_DIN,
  output logic              CPU_ENABLE,
  output logic              CPU_RDY,
  output logic              CPU_NMI_n,
  input  logic              NMI_IN_n,
  output logic [ADDR_W-1:0] BUS_ADDR,
  output logic [DATA_W-1:0] BUS_DOUT,
  output logic              BUS_RW_n,
  input  logic [DATA_W-1:0] BUS_DIN,
  output logic              DMA_BUSY
`ifdef CPU_2A03_STALL_CNT_EN
  ,
  output logic [15:0]       STALL_CNT
`endif
);

  localparam int unsigned IDX_W  = ADDR_W - DATA_W;
  localparam int unsigned DIV_W  = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam int unsigned HOLD_W = (NMI_HOLD < 2) ? 1 : $clog2(NMI_HOLD + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DMA_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [DIV_W-1:0]    div_nxt;
  logic                parity;
  logic [DATA_W-1:0]   page;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   dma_buf;
  logic                nmi_sync;
  logic                nmi_prev;
  logic                nmi_pend;
  logic [HOLD_W-1:0]   hold_cnt;

  // CPU_ENABLE is registered from the next count so CLK_DIV=1 gives a constant 1 out of reset.
  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      div_cnt    <= '0;
      CPU_ENABLE <= 1'b0;
    end else begin
      div_cnt    <= div_nxt;
      CPU_ENABLE <= (div_nxt == DIV_LAST);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state    <= S_IDLE;
      parity   <= 1'b0;
      CPU_RDY  <= 1'b1;
      DMA_BUSY <= 1'b0;
      page     <= '0;
      idx      <= '0;
      dma_buf  <= '0;
    end else if (CPU_ENABLE) begin
      parity <= ~parity;
      case (state)
        S_IDLE: begin
          if (!CPU_RW_n && (CPU_ADDR == DMA_REG_ADDR)) begin
            page     <= CPU_DOUT;
            idx      <= '0;
            state    <= S_HALT;
            CPU_RDY  <= 1'b0;
            DMA_BUSY <= 1'b1;
          end
        end
        // The following tick sees the flipped parity; only an even one may start a read.
        S_HALT:  state <= parity ? S_READ : S_ALIGN;
        S_ALIGN: state <= S_READ;
        S_READ: begin
          dma_buf <= BUS_DIN;
          state   <= S_WRITE;
        end
        S_WRITE: begin
          idx <= idx + IDX_W'(1);
          if (idx == IDX_LAST) begin
            state    <= S_IDLE;
            CPU_RDY  <= 1'b1;
            DMA_BUSY <= 1'b0;
          end else begin
            state <= S_READ;
          end
        end
        default: begin
          state    <= S_IDLE;
          CPU_RDY  <= 1'b1;
          DMA_BUSY <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    BUS_ADDR = CPU_ADDR;
    BUS_DOUT = CPU_DOUT;
    BUS_RW_n = CPU_RW_n;
    case (state)
      S_READ: begin
        BUS_ADDR = {page, idx};
        BUS_RW_n = 1'b1;
      end
      S_WRITE: begin
        BUS_ADDR = DMA_DST_ADDR;
        BUS_DOUT = dma_buf;
        BUS_RW_n = 1'b0;
      end
      default: ;
    endcase
    CPU_DIN = CPU_RW_n ? BUS_DIN : CPU_DOUT;
  end

  // An edge during an active pulse stays pending and starts a fresh pulse once the current one ends.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      nmi_sync  <= 1'b1;
      nmi_prev  <= 1'b1;
      nmi_pend  <= 1'b0;
      CPU_NMI_n <= 1'b1;
      hold_cnt  <= '0;
    end else begin
      nmi_sync <= NMI_IN_n;
      nmi_prev <= nmi_sync;
      if (CPU_ENABLE) begin
        if (!CPU_NMI_n) begin
          hold_cnt <= hold_cnt - HOLD_W'(1);
          if (hold_cnt == HOLD_W'(1)) CPU_NMI_n <= 1'b1;
        end else if (nmi_pend) begin
          CPU_NMI_n <= 1'b0;
          hold_cnt  <= HOLD_W'(NMI_HOLD);
          nmi_pend  <= 1'b0;
        end
      end
      if (nmi_prev && !nmi_sync) nmi_pend <= 1'b1;
    end
  end

`ifdef CPU_2A03_STALL_CNT_EN
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      STALL_CNT <= '0;
    end else if (CPU_ENABLE && !CPU_RDY && (STALL_CNT != '1)) begin
      STALL_CNT <= STALL_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_2a03_bus_ctrl.sv
// Directed bench for cpu_2a03_bus_ctrl: divider, passthrough, NMI pulses, DMA alignment and reset abort.
module tb_cpu_2a03_bus_ctrl;
  logic        CLK = 1'b0;
  logic        RESET_n;
  logic [15:0] CPU_ADDR;
  logic [7:0]  CPU_DOUT;
  logic        CPU_RW_n;
  logic [7:0]  CPU_DIN;
  logic        CPU_ENABLE;
  logic        CPU_RDY;
  logic        CPU_NMI_n;
  logic        NMI_IN_n;
  logic [15:0] BUS_ADDR;
  logic [7:0]  BUS_DOUT;
  logic        BUS_RW_n;
  logic [7:0]  BUS_DIN;
  logic        DMA_BUSY;
`ifdef CPU_2A03_STALL_CNT_EN
  logic [15:0] STALL_CNT;
`endif

  int errors = 0;
  int checks = 0;
  int unsigned tb_ticks;
  logic [7:0] mem [0:65535];

  typedef struct packed {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  dout;
    logic        busy;
  } ent_t;
  ent_t trace[$];

  always #5 CLK = ~CLK;

  cpu_2a03_bus_ctrl #(
    .ADDR_W(16), .DATA_W(8), .CLK_DIV(12),
    .DMA_REG_ADDR(16'h4014), .DMA_DST_ADDR(16'h2004),
    .DMA_LEN(256), .NMI_HOLD(2)
  ) dut (
    .CLK(CLK), .RESET_n(RESET_n),
    .CPU_ADDR(CPU_ADDR), .CPU_DOUT(CPU_DOUT), .CPU_RW_n(CPU_RW_n),
    .CPU_DIN(CPU_DIN), .CPU_ENABLE(CPU_ENABLE), .CPU_RDY(CPU_RDY),
    .CPU_NMI_n(CPU_NMI_n), .NMI_IN_n(NMI_IN_n),
    .BUS_ADDR(BUS_ADDR), .BUS_DOUT(BUS_DOUT), .BUS_RW_n(BUS_RW_n),
    .BUS_DIN(BUS_DIN), .DMA_BUSY(DMA_BUSY)
`ifdef CPU_2A03_STALL_CNT_EN
    , .STALL_CNT(STALL_CNT)
`endif
  );

  assign BUS_DIN = mem[BUS_ADDR];

  always @(posedge CLK) begin
    if (!RESET_n) tb_ticks <= 0;
    else if (CPU_ENABLE) tb_ticks <= tb_ticks + 1;
  end

  always @(posedge CLK) begin
    if (RESET_n && CPU_ENABLE && !CPU_RDY)
      trace.push_back({BUS_ADDR, BUS_RW_n, BUS_DOUT, DMA_BUSY});
  end

  // Returns at the falling edge just after the next tick edge.
  task automatic next_tick();
    int n = 0;
    @(negedge CLK);
    while (CPU_ENABLE !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) begin
      $display("FAIL tick_timeout: CPU_ENABLE=%b required pulse within 100 CLKs", CPU_ENABLE);
      $fatal(1, "no CPU_ENABLE");
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET_n  = 1'b0;
    NMI_IN_n = 1'b1;
    CPU_ADDR = 16'hFFF0;
    CPU_DOUT = 8'h00;
    CPU_RW_n = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({CPU_ENABLE, CPU_RDY, CPU_NMI_n, DMA_BUSY} !== 4'b0110)
      $display("FAIL reset_outputs: got en/rdy/nmi/busy=%b want 0110",
               {CPU_ENABLE, CPU_RDY, CPU_NMI_n, DMA_BUSY});
    checks++;
    if (BUS_ADDR !== 16'hFFF0 || BUS_RW_n !== 1'b1)
      $display("FAIL reset_bus_mux: got addr=%h rw=%b want FFF0 1", BUS_ADDR, BUS_RW_n);
    if (BUS_ADDR !== 16'hFFF0 || BUS_RW_n !== 1'b1) errors++;
    if ({CPU_ENABLE, CPU_RDY, CPU_NMI_n, DMA_BUSY} !== 4'b0110) errors++;
`ifdef CPU_2A03_STALL_CNT_EN
    checks++;
    if (STALL_CNT !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall_cnt: got %0d want 0", STALL_CNT);
    end
`endif
  endtask

  task automatic test_divider();
    int cnt = 0;
    int first = 0;
    int last = 0;
    int gap_bad = 0;
    RESET_n = 1'b0;
    @(negedge CLK);
    RESET_n = 1'b1;
    for (int n = 1; n <= 120; n++) begin
      if (n > 1) @(negedge CLK);
      if (CPU_ENABLE === 1'b1) begin
        if (cnt == 0) first = n;
        else if (n - last != 12) gap_bad++;
        last = n;
        cnt++;
      end
    end
    checks++;
    if (cnt !== 10) begin errors++; $display("FAIL div_count: got %0d want 10", cnt); end
    checks++;
    if (first !== 12) begin errors++; $display("FAIL div_first: got %0d want 12", first); end
    checks++;
    if (gap_bad !== 0) begin errors++; $display("FAIL div_spacing: got %0d bad gaps want 0", gap_bad); end
  endtask

  task automatic test_passthrough();
    @(negedge CLK);
    CPU_ADDR = 16'h0000; CPU_DOUT = 8'hA5; CPU_RW_n = 1'b0;
    #1;
    checks++;
    if ({BUS_ADDR, BUS_RW_n, BUS_DOUT, CPU_DIN} !== {16'h0000, 1'b0, 8'hA5, 8'hA5}) begin
      errors++;
      $display("FAIL pass_write: got addr=%h rw=%b dout=%h din=%h want 0000 0 A5 A5",
               BUS_ADDR, BUS_RW_n, BUS_DOUT, CPU_DIN);
    end
    CPU_ADDR = 16'h1234; CPU_RW_n = 1'b1;
    #1;
    checks++;
    if ({BUS_ADDR, BUS_RW_n, CPU_DIN} !== {16'h1234, 1'b1, 8'h3C}) begin
      errors++;
      $display("FAIL pass_read: got addr=%h rw=%b din=%h want 1234 1 3C", BUS_ADDR, BUS_RW_n, CPU_DIN);
    end
    CPU_ADDR = 16'hFFF0; CPU_DOUT = 8'h00;
  endtask

  task automatic test_nmi_single();
    logic [4:0] v = '0;
    next_tick();
    checks++;
    if (CPU_NMI_n !== 1'b1) begin errors++; $display("FAIL nmi_idle: got %b want 1", CPU_NMI_n); end
    NMI_IN_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      next_tick();
      v = {v[3:0], CPU_NMI_n};
    end
    NMI_IN_n = 1'b1;
    checks++;
    if (v !== 5'b00111) begin errors++; $display("FAIL nmi_single: got %b want 00111", v); end
    next_tick();
  endtask

  task automatic test_nmi_back_to_back();
    logic [7:0] v = '0;
    next_tick();
    NMI_IN_n = 1'b0;
    next_tick();
    v = {v[6:0], CPU_NMI_n};
    NMI_IN_n = 1'b1;
    next_tick();
    v = {v[6:0], CPU_NMI_n};
    NMI_IN_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      next_tick();
      v = {v[6:0], CPU_NMI_n};
    end
    NMI_IN_n = 1'b1;
    checks++;
    if (v !== 8'b00100111) begin errors++; $display("FAIL nmi_back_to_back: got %b want 00100111", v); end
    next_tick();
  endtask

  // Issues the $4014 write on a tick of the requested parity; returns just after that tick.
  task automatic trigger_dma(input bit odd, input string tag);
    next_tick();
    if (tb_ticks[0] !== odd) next_tick();
    CPU_ADDR = 16'h4014; CPU_RW_n = 1'b0; CPU_DOUT = 8'h02;
    #1;
    checks++;
    if ({BUS_ADDR, BUS_RW_n, BUS_DOUT} !== {16'h4014, 1'b0, 8'h02}) begin
      errors++;
      $display("FAIL %s_trigger_bus: got addr=%h rw=%b dout=%h want 4014 0 02", tag, BUS_ADDR, BUS_RW_n, BUS_DOUT);
    end
    trace.delete();
    next_tick();
    CPU_ADDR = 16'hFFF0; CPU_RW_n = 1'b1; CPU_DOUT = 8'h00;
    checks++;
    if ({CPU_RDY, DMA_BUSY} !== 2'b01) begin
      errors++;
      $display("FAIL %s_stall_start: got rdy/busy=%b want 01", tag, {CPU_RDY, DMA_BUSY});
    end
  endtask

  task automatic check_trace(input int unsigned align, input string tag);
    int unsigned exp_len = 1 + align + 512;
    int bad = 0;
    int first = -1;
    int writes = 0;
    logic [15:0] ea;
    logic        erw;
    logic [7:0]  ed;
    checks++;
    if (trace.size() !== exp_len) begin
      errors++;
      $display("FAIL %s_halted_ticks: got %0d want %0d", tag, trace.size(), exp_len);
    end
    for (int unsigned k = 0; k < trace.size() && k < exp_len; k++) begin
      ed = trace[k].dout;
      if (k < 1 + align) begin
        ea = 16'hFFF0; erw = 1'b1;
      end else begin
        int unsigned j = k - 1 - align;
        logic [7:0] i8 = 8'(j / 2);
        if (j % 2 == 0) begin
          ea = {8'h02, i8}; erw = 1'b1;
        end else begin
          ea = 16'h2004; erw = 1'b0; ed = i8 ^ 8'h5A;
          if (trace[k].addr === 16'h2004 && trace[k].rw === 1'b0) writes++;
        end
      end
      if ({trace[k].addr, trace[k].rw, trace[k].dout, trace[k].busy} !== {ea, erw, ed, 1'b1}) begin
        if (first < 0) first = k;
        bad++;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s_sequence: got %0d bad entries (first at %0d) want 0", tag, bad, first);
    end
    checks++;
    if (writes !== 256) begin errors++; $display("FAIL %s_writes: got %0d want 256", tag, writes); end
  endtask

  task automatic run_dma(input bit odd, input string tag);
    int n = 0;
    trigger_dma(odd, tag);
    while (CPU_RDY !== 1'b1 && n < 800) begin
      next_tick();
      n++;
    end
    checks++;
    if ({CPU_RDY, DMA_BUSY} !== 2'b10) begin
      errors++;
      $display("FAIL %s_done: got rdy/busy=%b want 10 after %0d ticks", tag, {CPU_RDY, DMA_BUSY}, n);
    end
    check_trace(odd ? 1 : 0, tag);
  endtask

  task automatic test_reset_mid_dma();
    logic [7:0] v = '0;
    trigger_dma(1'b0, "abort");
    repeat (50) next_tick();
    NMI_IN_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next_tick();
      v = {v[5:0], CPU_NMI_n, CPU_RDY};
    end
    NMI_IN_n = 1'b1;
    checks++;
    if (v !== 8'b00001010) begin errors++; $display("FAIL nmi_during_dma: got nmi/rdy=%b want 00001010", v); end
    repeat (147) next_tick();
    checks++;
    if ({BUS_ADDR, BUS_RW_n, CPU_RDY} !== {16'h0264, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL abort_byte100: got addr=%h rw=%b rdy=%b want 0264 1 0", BUS_ADDR, BUS_RW_n, CPU_RDY);
    end
    RESET_n = 1'b0;
    @(negedge CLK);
    RESET_n = 1'b1;
    #1;
    checks++;
    if ({CPU_RDY, DMA_BUSY, BUS_ADDR, BUS_RW_n} !== {1'b1, 1'b0, 16'hFFF0, 1'b1}) begin
      errors++;
      $display("FAIL abort_idle: got rdy=%b busy=%b addr=%h rw=%b want 1 0 FFF0 1",
               CPU_RDY, DMA_BUSY, BUS_ADDR, BUS_RW_n);
    end
`ifdef CPU_2A03_STALL_CNT_EN
    checks++;
    if (STALL_CNT !== 16'd0) begin errors++; $display("FAIL abort_stall_cnt: got %0d want 0", STALL_CNT); end
`endif
    run_dma(1'b0, "restart");
`ifdef CPU_2A03_STALL_CNT_EN
    checks++;
    if (STALL_CNT !== 16'd513) begin errors++; $display("FAIL restart_stall_cnt: got %0d want 513", STALL_CNT); end
`endif
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
    mem[16'h1234] = 8'h3C;
    test_reset();
    test_divider();
    test_passthrough();
    test_nmi_single();
    test_nmi_back_to_back();
    run_dma(1'b0, "even");
    run_dma(1'b1, "odd");
`ifdef CPU_2A03_STALL_CNT_EN
    checks++;
    if (STALL_CNT !== 16'd1027) begin errors++; $display("FAIL stall_cnt_total: got %0d want 1027", STALL_CNT); end
`endif
    test_reset_mid_dma();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
